// File: rtl/seq_detector_pkg.sv
// Shared definitions for the serial pattern detector.
//   state_t : detector FSM state encoding (IDLE / FILL / RUN)
//   W_DEF   : default pattern length in bits
//   CW_DEF  : default match-counter width
package seq_detector_pkg;

    localparam int unsigned W_DEF  = 5;
    localparam int unsigned CW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear, wins over inc
//   inc        : add one this cycle (held at all-ones once reached)
//   count      : registered count value
module sat_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with overlapping match detection.
// Optional match counter is built only when SEQ_DETECTOR_COUNT_EN is defined.
//   clk, reset  : clock, asynchronous active-high reset
//   pattern     : target sequence, pattern[0] is the earliest bit in time
//   load        : latch pattern and restart detection (wins over in_valid)
//   in_bit      : serial data bit
//   in_valid    : qualifies in_bit this cycle
//   detect      : one-cycle registered pulse, one cycle after the completing bit
//   armed       : high while the FSM is in RUN
//   count_clr   : synchronous clear of match_count   (SEQ_DETECTOR_COUNT_EN only)
//   match_count : saturating count of detect pulses  (SEQ_DETECTOR_COUNT_EN only)
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:W-1] pattern,
    input  logic         load,
    input  logic         in_bit,
    input  logic         in_valid,
    output logic         detect,
    output logic         armed
`ifdef SEQ_DETECTOR_COUNT_EN
    ,
    input  logic          count_clr,
    output logic [CW-1:0] match_count
`endif
);

    // Fill counter must be able to hold the value W itself.
    localparam int unsigned FW = $clog2(W + 1);

    if ((W < 2) || (W > 16) || (CW < 1)) begin : g_param_check
        $error("seq_detector: illegal parameters W=%0d CW=%0d", W, CW);
    end

    state_t        state;
    logic [0:W-1]  pat_q;
    logic [0:W-1]  hist;
    logic [FW-1:0] fill;

    logic          accept_c;
    logic [0:W-1]  hist_next_c;
    logic [FW-1:0] fill_next_c;
    logic          full_next_c;
    logic          hit_c;

    // Bits are only consumed once a pattern exists, and never on a load cycle.
    assign accept_c    = in_valid && !load && (state != ST_IDLE);
    // Oldest bit sits at index 0, matching the pattern's time ordering.
    assign hist_next_c = {hist[1:W-1], in_bit};
    assign fill_next_c = (fill == FW'(W)) ? fill : fill + FW'(1);
    assign full_next_c = (fill_next_c == FW'(W));
    assign hit_c       = accept_c && full_next_c && (hist_next_c == pat_q);

    // Detector FSM with registered detect/armed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            pat_q  <= '0;
            hist   <= '0;
            fill   <= '0;
            detect <= 1'b0;
            armed  <= 1'b0;
        end else begin
            detect <= 1'b0;
            if (load) begin
                pat_q <= pattern;
                hist  <= '0;
                fill  <= '0;
                state <= ST_FILL;
                armed <= 1'b0;
            end else if (accept_c) begin
                hist   <= hist_next_c;
                fill   <= fill_next_c;
                detect <= hit_c;
                if (full_next_c) begin
                    state <= ST_RUN;
                    armed <= 1'b1;
                end
            end
        end
    end

`ifdef SEQ_DETECTOR_COUNT_EN
    sat_counter #(
        .CW (CW)
    ) u_sat_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (count_clr),
        .inc   (detect),
        .count (match_count)
    );
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed self-checking bench for seq_detector (default W=5).
// Counter checks run only when SEQ_DETECTOR_COUNT_EN is defined; a second
// instance with CW=2 shares all inputs and is used for saturation checks.
module tb_seq_detector;
    import seq_detector_pkg::*;

    localparam int unsigned W = 5;

    logic         clk;
    logic         reset;
    logic [0:W-1] pattern;
    logic         load;
    logic         in_bit;
    logic         in_valid;
    logic         detect;
    logic         armed;
`ifdef SEQ_DETECTOR_COUNT_EN
    logic         count_clr;
    logic [15:0]  match_count;
    logic         detect2;
    logic         armed2;
    logic [1:0]   match_count2;
`endif

    int checks;
    int passes;

    seq_detector #(.W(W), .CW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .pattern     (pattern),
        .load        (load),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .detect      (detect),
        .armed       (armed)
`ifdef SEQ_DETECTOR_COUNT_EN
        ,
        .count_clr   (count_clr),
        .match_count (match_count)
`endif
    );

`ifdef SEQ_DETECTOR_COUNT_EN
    seq_detector #(.W(W), .CW(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .pattern     (pattern),
        .load        (load),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .detect      (detect2),
        .armed       (armed2),
        .count_clr   (count_clr),
        .match_count (match_count2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one valid bit at the next rising edge, then sample 1 time unit later.
    task automatic send_bit(input logic b);
        in_bit   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [0:W-1] p);
        pattern = p;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load    = 1'b0;
        pattern = '0;
    endtask

    task automatic test_reset();
        logic [0:4] bits;
        bits = 5'b10011;
        reset = 1'b1;
        repeat (2) idle_cycle();
        checks++;
        if (detect !== 1'b0) $display("FAIL reset_detect got=%b exp=0", detect); else passes++;
        checks++;
        if (armed !== 1'b0) $display("FAIL reset_armed got=%b exp=0", armed); else passes++;
        checks++;
        if (dut.state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE); else passes++;
`ifdef SEQ_DETECTOR_COUNT_EN
        checks++;
        if (match_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", match_count); else passes++;
`endif
        reset = 1'b0;
        idle_cycle();
        // Without a load the detector stays IDLE and ignores data.
        for (int i = 0; i < 5; i++) begin
            send_bit(bits[i]);
            checks++;
            if (detect !== 1'b0 || armed !== 1'b0)
                $display("FAIL idle_nodetect bit=%0d got det=%b armed=%b exp det=0 armed=0", i, detect, armed);
            else passes++;
        end
    endtask

    task automatic test_basic();
        logic [0:4] bits;
        logic [0:4] exp_det;
        bits    = 5'b10011;
        exp_det = 5'b00001;
        do_load(5'b10011);
        checks++;
        if (detect !== 1'b0 || armed !== 1'b0)
            $display("FAIL basic_after_load got det=%b armed=%b exp det=0 armed=0", detect, armed);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            send_bit(bits[i]);
            checks++;
            if (detect !== exp_det[i]) $display("FAIL basic_detect bit=%0d got=%b exp=%b", i, detect, exp_det[i]); else passes++;
            checks++;
            if (armed !== ((i >= 4) ? 1'b1 : 1'b0)) $display("FAIL basic_armed bit=%0d got=%b exp=%b", i, armed, (i >= 4)); else passes++;
        end
        idle_cycle();
        checks++;
        if (detect !== 1'b0 || armed !== 1'b1)
            $display("FAIL basic_pulse_width got det=%b armed=%b exp det=0 armed=1", detect, armed);
        else passes++;
    endtask

    task automatic test_overlap();
        logic [0:6] bits;
        logic [0:6] exp_det;
        bits    = 7'b1010101;
        exp_det = 7'b0000101;
`ifdef SEQ_DETECTOR_COUNT_EN
        count_clr = 1'b1;
`endif
        do_load(5'b10101);
`ifdef SEQ_DETECTOR_COUNT_EN
        count_clr = 1'b0;
`endif
        for (int i = 0; i < 7; i++) begin
            send_bit(bits[i]);
            checks++;
            if (detect !== exp_det[i]) $display("FAIL overlap_detect bit=%0d got=%b exp=%b", i, detect, exp_det[i]); else passes++;
        end
        idle_cycle();
        checks++;
        if (detect !== 1'b0) $display("FAIL overlap_tail got=%b exp=0", detect); else passes++;
`ifdef SEQ_DETECTOR_COUNT_EN
        checks++;
        if (match_count !== 16'd2) $display("FAIL overlap_count got=%0d exp=2", match_count); else passes++;
`endif
    endtask

    task automatic test_gaps();
        logic [0:2] tail;
        logic [0:2] exp_det;
        tail    = 3'b011;
        exp_det = 3'b001;
        do_load(5'b10011);
        send_bit(1'b1);
        send_bit(1'b0);
        // Toggle in_bit while in_valid is low; it must be ignored.
        in_bit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            checks++;
            if (detect !== 1'b0 || armed !== 1'b0)
                $display("FAIL gap_quiet cycle=%0d got det=%b armed=%b exp det=0 armed=0", i, detect, armed);
            else passes++;
        end
        in_bit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_bit(tail[i]);
            checks++;
            if (detect !== exp_det[i]) $display("FAIL gap_detect bit=%0d got=%b exp=%b", i + 2, detect, exp_det[i]); else passes++;
        end
        checks++;
        if (armed !== 1'b1) $display("FAIL gap_armed got=%b exp=1", armed); else passes++;
    endtask

    task automatic test_load_collision();
        logic [0:8] bits;
        logic [0:8] exp_det;
        bits    = 9'b001110011;
        exp_det = 9'b000000001;
        checks++;
        if (armed !== 1'b1) $display("FAIL collide_pre_armed got=%b exp=1", armed); else passes++;
        pattern  = 5'b10011;
        load     = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk);
        #1;
        load     = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        pattern  = '0;
        checks++;
        if (dut.state !== ST_FILL) $display("FAIL collide_state got=%0d exp=%0d", dut.state, ST_FILL); else passes++;
        checks++;
        if (armed !== 1'b0 || detect !== 1'b0)
            $display("FAIL collide_outputs got det=%b armed=%b exp det=0 armed=0", detect, armed);
        else passes++;
        for (int i = 0; i < 9; i++) begin
            send_bit(bits[i]);
            checks++;
            if (detect !== exp_det[i]) $display("FAIL collide_detect bit=%0d got=%b exp=%b", i, detect, exp_det[i]); else passes++;
            checks++;
            if (armed !== ((i >= 4) ? 1'b1 : 1'b0)) $display("FAIL collide_armed bit=%0d got=%b exp=%b", i, armed, (i >= 4)); else passes++;
        end
    endtask

    task automatic test_reset_midstream();
        // Reset takes effect without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (armed !== 1'b0 || dut.state !== ST_IDLE)
            $display("FAIL async_reset got armed=%b state=%0d exp armed=0 state=%0d", armed, dut.state, ST_IDLE);
        else passes++;
        idle_cycle();
        reset = 1'b0;
        idle_cycle();
        do_load(5'b10011);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (detect !== 1'b0 || armed !== 1'b0 || dut.state !== ST_IDLE)
            $display("FAIL midreset_outputs got det=%b armed=%b state=%0d exp det=0 armed=0 state=%0d",
                     detect, armed, dut.state, ST_IDLE);
        else passes++;
`ifdef SEQ_DETECTOR_COUNT_EN
        checks++;
        if (match_count !== 16'd0) $display("FAIL midreset_count got=%0d exp=0", match_count); else passes++;
`endif
        idle_cycle();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send_bit(1'b1);
            checks++;
            if (detect !== 1'b0 || armed !== 1'b0)
                $display("FAIL midreset_tail bit=%0d got det=%b armed=%b exp det=0 armed=0", i, detect, armed);
            else passes++;
        end
        idle_cycle();
        checks++;
        if (detect !== 1'b0 || dut.state !== ST_IDLE)
            $display("FAIL midreset_final got det=%b state=%0d exp det=0 state=%0d", detect, dut.state, ST_IDLE);
        else passes++;
    endtask

`ifdef SEQ_DETECTOR_COUNT_EN
    task automatic test_saturation();
        count_clr = 1'b1;
        do_load(5'b11111);
        count_clr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b1);
            checks++;
            if (detect2 !== ((i >= 4) ? 1'b1 : 1'b0)) $display("FAIL sat_detect bit=%0d got=%b exp=%b", i, detect2, (i >= 4)); else passes++;
        end
        idle_cycle();
        checks++;
        if (match_count2 !== 2'd3) $display("FAIL sat_hold got=%0d exp=3", match_count2); else passes++;
        checks++;
        if (match_count !== 16'd5) $display("FAIL sat_wide_count got=%0d exp=5", match_count); else passes++;
        send_bit(1'b1);
        checks++;
        if (detect2 !== 1'b1) $display("FAIL sat_pre_clr_detect got=%b exp=1", detect2); else passes++;
        // Clear lands on the same edge as a counted detect; clear must win.
        count_clr = 1'b1;
        idle_cycle();
        count_clr = 1'b0;
        checks++;
        if (match_count2 !== 2'd0) $display("FAIL sat_clr_priority got=%0d exp=0", match_count2); else passes++;
        checks++;
        if (match_count !== 16'd0) $display("FAIL sat_clr_wide got=%0d exp=0", match_count); else passes++;
        idle_cycle();
        checks++;
        if (match_count2 !== 2'd0) $display("FAIL sat_clr_stays got=%0d exp=0", match_count2); else passes++;
    endtask
`endif

    initial begin
        checks   = 0;
        passes   = 0;
        reset    = 1'b1;
        pattern  = '0;
        load     = 1'b0;
        in_bit   = 1'b0;
        in_valid = 1'b0;
`ifdef SEQ_DETECTOR_COUNT_EN
        count_clr = 1'b0;
`endif
        test_reset();
        test_basic();
        test_overlap();
        test_gaps();
        test_load_collision();
        test_reset_midstream();
`ifdef SEQ_DETECTOR_COUNT_EN
        test_saturation();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL have parameter W, default 5, meaning pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter CW, default 16, meaning match-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port pattern, input, [0:W-1], the target sequence; pattern[0] is the earliest bit in time.
REQ-006 SHALL have port load, input, 1, a strobe that latches pattern and restarts detection.
REQ-007 SHALL have port in_bit, input, 1, the serial data bit from the upstream generator.
REQ-008 SHALL have port in_valid, input, 1, which qualifies in_bit for the current cycle.
REQ-009 SHALL have port detect, output, 1, a one-cycle registered match pulse.
REQ-010 SHALL have port armed, output, 1, which is high when state is RUN.
REQ-011 SHALL have port match_count, output, CW, the number of matches (only when counting is enabled).
REQ-012 SHALL have port count_clr, input, 1, a synchronous clear for match_count (only when counting is enabled).

Function
REQ-013 SHALL implement the FSM states IDLE, FILL and RUN.
- IDLE: no pattern loaded.
- load -> FILL.
- FILL -> RUN once W valid bits have been accepted since load.
- RUN stays in RUN.
- load from any state -> FILL.
REQ-014 SHALL latch pattern into an internal register on load; the pattern input is ignored at all other times.
REQ-015 SHALL shift in_bit into a W-bit history register only on cycles where in_valid=1 and load=0.
- Cycles with in_valid=0 leave all state unchanged.
REQ-016 SHALL clear the history register and the fill counter on load; the fill counter saturates at W.
REQ-017 SHALL give load priority over in_valid when both are high in the same cycle; that bit is discarded.
REQ-018 SHALL assert detect for exactly one cycle, on the edge after an accepted bit completes a history equal to the latched pattern.
- This applies in RUN, or on the FILL->RUN transition bit.
- Latency is 1 cycle from the accepted bit.
REQ-019 SHALL support overlapping detection, e.g. pattern 10101 matches twice in 1010101.
REQ-020 SHALL never assert detect in IDLE, in FILL before W bits have been accepted, or in the cycle after load.

Reset
REQ-021 SHALL on reset drive the state to IDLE, the history register, latched pattern and fill counter to 0, detect=0, armed=0 and match_count=0.
REQ-022 SHALL abort any partial match when reset is asserted mid-stream; no detect is produced for bits accepted before reset.

Configuration
REQ-023 SHALL compile the match counter in only when macro SEQ_DETECTOR_COUNT_EN is defined.
- match_count increments by 1 on every cycle detect is asserted.
- match_count saturates at 2^CW-1.
- count_clr zeroes it; count_clr has priority over an increment in the same cycle.
REQ-024 SHALL, without SEQ_DETECTOR_COUNT_EN, omit the match_count and count_clr ports and the counter logic; all other behaviour is unchanged.

Structure
REQ-025 SHALL place the FSM state enum typedef and the default W and CW constants in shared package seq_detector_pkg.
REQ-026 SHALL implement the saturating counter as sub-module sat_counter, instantiated only under SEQ_DETECTOR_COUNT_EN.

Verification
REQ-027 SHALL test a basic match: load 10011, then feed 1,0,0,1,1 valid -> a single detect pulse one cycle after the 5th bit; armed rises after the 5th bit.
REQ-028 SHALL test overlap: load 10101, feed 1010101 -> detect after bit 5 and after bit 7; match_count=2.
REQ-029 SHALL test gaps: 10011 with in_valid=0 for 3 cycles between bits 2 and 3 -> detect still occurs after bit 5; there is no spurious pulse during the gap.
REQ-030 SHALL test load collision: load=1 and in_valid=1 with in_bit=1 in the same cycle -> the bit is discarded and the state is FILL; only the next 5 valid bits can form a match.
REQ-031 SHALL test reset mid-stream: assert reset after 3 bits of 10011 -> all outputs go to 0 and state goes to IDLE; the remaining 2 bits produce no detect.
REQ-032 SHALL test saturation: CW=2, with 5 consecutive matches -> match_count holds at 3; count_clr together with detect -> 0.
